// File: rtl/seq_pattern_ctrl.sv
// Programmable pattern sequencer: plays a DEPTH-entry (data, dv) table
// as a registered stream, looping it a set number of passes or until stopped.
//
// Ports:
//   sclk, rst_n       clock, async active-low reset
//   cfg_we/addr/data/dv  table write port, accepted only while idle
//   cfg_len, cfg_loops   entries per pass and pass count, latched on start
//   start, stop          single-cycle run/abort requests
//   o_data, o_dv         registered pattern stream
//   busy                 high on every cycle a table entry is on the outputs
//   done                 one-cycle pulse after the final pass completes
module seq_pattern_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DW     = 8,
    parameter int LOOP_W = 4
) (
    input  logic                     sclk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DW-1:0]            cfg_data,
    input  logic                     cfg_dv,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic [LOOP_W-1:0]        cfg_loops,
    input  logic                     start,
    input  logic                     stop,
    output logic [DW-1:0]            o_data,
    output logic                     o_dv,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     tbl_data [DEPTH];
    logic [DEPTH-1:0]  tbl_dv;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic              inf_q, inf_d;
    logic [DW-1:0]     data_d;
    logic              dv_d, busy_d, done_d;
    logic              go, last_idx, last_pass;
    logic [AW:0]       len_clamp;

    assign go = start && !stop;

    // A zero or oversized length means "use the whole table".
    assign len_clamp = (cfg_len == '0 || cfg_len > (AW+1)'(DEPTH))
                     ? (AW+1)'(DEPTH) : cfg_len;

    assign last_idx  = ({1'b0, idx_q} == len_q - (AW+1)'(1));
    assign last_pass = !inf_q && (pass_q == LOOP_W'(1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_data[i] <= '0;
            end
            tbl_dv <= '0;
        end else if (cfg_we && state_q == S_IDLE) begin
            tbl_data[cfg_addr] <= cfg_data;
            tbl_dv[cfg_addr]   <= cfg_dv;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pass_d  = pass_q;
        inf_d   = inf_q;
        data_d  = '0;
        dv_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    len_d   = len_clamp;
                    pass_d  = cfg_loops;
                    inf_d   = (cfg_loops == '0);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    data_d = tbl_data[idx_q];
                    dv_d   = tbl_dv[idx_q];
                    busy_d = 1'b1;
                    if (last_idx) begin
                        idx_d = '0;
                        if (!inf_q) begin
                            if (pass_q != '0) begin
                                pass_d = pass_q - LOOP_W'(1);
                            end
                            if (last_pass) begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            pass_q  <= '0;
            inf_q   <= 1'b0;
            o_data  <= '0;
            o_dv    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            inf_q   <= inf_d;
            o_data  <= data_d;
            o_dv    <= dv_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scoreboard bench for seq_pattern_ctrl: a table/length/loop model
// predicts each output cycle; a negedge monitor pops and compares.
module tb_seq_pattern_ctrl;
    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       cfg_dv = 1'b0;
    logic [3:0] cfg_len = '0;
    logic [3:0] cfg_loops = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] o_data;
    logic       o_dv;
    logic       busy;
    logic       done;

    seq_pattern_ctrl dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_dv    (cfg_dv),
        .cfg_len   (cfg_len),
        .cfg_loops (cfg_loops),
        .start     (start),
        .stop      (stop),
        .o_data    (o_data),
        .o_dv      (o_dv),
        .busy      (busy),
        .done      (done)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [7:0] data;
        logic       dv;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] m_data [8];
    logic       m_dv [8];
    bit         running = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (rst_n) begin
            if (busy || done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: data=%h dv=%b busy=%b done=%b",
                             o_data, o_dv, busy, done);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream", {21'd0, o_data, o_dv, busy, done},
                        {21'd0, mon_e.data, mon_e.dv, !mon_e.done, mon_e.done});
                end
            end else begin
                chk("idle_zero", {23'd0, o_data, o_dv}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    task automatic clr_model();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_dv[i]   = 1'b0;
        end
    endtask

    task automatic wr(int a, logic [7:0] d, logic v);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = d;
        cfg_dv   = v;
        cyc();
        cfg_we = 1'b0;
        if (!running) begin
            m_data[a] = d;
            m_dv[a]   = v;
        end
    endtask

    function automatic int eff_len(int len);
        return (len == 0 || len > 8) ? 8 : len;
    endfunction

    task automatic push_finite(int len, int loops);
        int n;
        n = eff_len(len);
        for (int p = 0; p < loops; p++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{m_data[i], m_dv[i], 1'b0});
            end
        end
        exp_q.push_back('{8'h00, 1'b0, 1'b1});
    endtask

    task automatic kick(int len, int loops);
        cfg_len   = 4'(len);
        cfg_loops = 4'(loops);
        start     = 1'b1;
        cyc();
        start   = 1'b0;
        running = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            cyc();
            t++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d outputs still pending", exp_q.size());
            exp_q.delete();
        end
        cyc();
        running = 1'b0;
        cyc();
    endtask

    task automatic run_finite(int len, int loops);
        push_finite(len, loops);
        kick(len, loops);
        drain();
    endtask

    // Endless run for n output cycles, then either stop or async reset.
    task automatic run_inf(int len, int n, bit use_reset);
        int e;
        e = eff_len(len);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{m_data[i % e], m_dv[i % e], 1'b0});
        end
        kick(len, 0);
        repeat (n) cyc();
        if (!use_reset) begin
            stop = 1'b1;
            cyc();
            stop = 1'b0;
            chk("stop_busy", {31'd0, busy}, 32'd0);
            chk("stop_done", {31'd0, done}, 32'd0);
            chk("stop_out", {23'd0, o_data, o_dv}, 32'd0);
        end else begin
            #5;
            rst_n = 1'b0;
            #1;
            chk("areset_out", {22'd0, o_data, o_dv, busy}, 32'd0);
            clr_model();
            cyc();
            rst_n = 1'b1;
        end
        running = 1'b0;
        chk("inf_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (3) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr_model();
        repeat (2) cyc();
        chk("rst_out", {21'd0, o_data, o_dv, busy, done}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // empty table plays zeros then completes
        run_finite(3, 1);

        // two passes of a three-entry pattern
        wr(0, 8'h07, 1'b1);
        wr(1, 8'h00, 1'b0);
        wr(2, 8'h05, 1'b1);
        run_finite(3, 2);

        // endless alternation aborted by stop
        wr(0, 8'hAA, 1'b1);
        wr(1, 8'h55, 1'b1);
        run_inf(2, 22, 1'b0);

        // start together with stop stays idle
        cfg_len   = 4'd3;
        cfg_loops = 4'd1;
        start     = 1'b1;
        stop      = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) cyc();

        // length 0 plays the full table
        for (int i = 0; i < 8; i++) begin
            wr(i, 8'(i), 1'b1);
        end
        run_finite(0, 1);

        // writes and restarts during a run are ignored
        wr(0, 8'h07, 1'b1);
        wr(1, 8'h00, 1'b0);
        wr(2, 8'h05, 1'b1);
        push_finite(3, 2);
        kick(3, 2);
        cyc();
        wr(0, 8'hFF, 1'b1);
        cfg_len   = 4'd1;
        cfg_loops = 4'd5;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        drain();
        run_finite(3, 1);

        // async reset mid-run wipes the table
        wr(0, 8'hAA, 1'b1);
        wr(1, 8'h55, 1'b1);
        run_inf(2, 5, 1'b1);
        run_finite(3, 1);

        // randomized tables, lengths and pass counts
        repeat (8) begin
            repeat ($urandom_range(1, 4)) begin
                wr($urandom_range(0, 7), 8'($urandom), 1'($urandom));
            end
            run_finite($urandom_range(0, 15), $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
